// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: FSM state encoding and chunk sizing helpers.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter width never drops below one bit, even for a single-chunk build.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit subtract with borrow: {bout, d} = a - b - bin.
module sub_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             bin_i,
    output logic [CHUNK-1:0] d_o,
    output logic             bout_o
);

    logic [CHUNK:0] diff;

    // One extra bit on top catches the borrow as the wrapped sign.
    assign diff   = {1'b0, a_i} - {1'b0, b_i} - {{CHUNK{1'b0}}, bin_i};
    assign d_o    = diff[CHUNK-1:0];
    assign bout_o = diff[CHUNK];

endmodule

// File: rtl/sub64_seq.sv
// Multi-cycle subtractor D = A - B, one CHUNK per clock, LSB chunk first,
// ripple borrow carried in a register between chunks.
module sub64_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             BOUT
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CNT_W  = cnt_w(NCHUNK);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic [CHUNK-1:0] chunk_d;
    logic             chunk_bout;

    // Operands are shifted right each RUN cycle, so the live chunk is always the low slice.
    sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
        .a_i    (a_q[CHUNK-1:0]),
        .b_i    (b_q[CHUNK-1:0]),
        .bin_i  (borrow_q),
        .d_o    (chunk_d),
        .bout_o (chunk_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            d_q         <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= B;
                        cnt_q      <= '0;
                        borrow_q   <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q      <= a_q >> CHUNK;
                    b_q      <= b_q >> CHUNK;
                    borrow_q <= chunk_bout;
                    cnt_q    <= cnt_q + 1'b1;
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            d_q[i*CHUNK +: CHUNK] <= chunk_d;
                        end
                    end
                    if (cnt_q == LAST) begin
                        bout_q      <= chunk_bout;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign D         = d_q;
    assign BOUT      = bout_q;

endmodule
